// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the RV32 execute stage
package ex_pkg;
  localparam int XLEN = 32;
  localparam int RF_AW = 5;
  localparam int MUL_CYCLES = 32;
  typedef enum logic [2:0] {OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND} alu_op_e;
  typedef enum logic {ST_IDLE, ST_BUSY} mul_state_e;
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  wdata;
    logic [RF_AW-1:0] waddr;
    logic             rf_we;
    logic             mem_we;
    logic             mem2rf;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
  } ex_mem_t;
endpackage

// File: rtl/ex_if.sv
// ex_if: decode/execute inputs and execute/memory outputs of ex_stage
interface ex_if;
  import ex_pkg::*;
  logic             valid_i, flush_i, has_imm_i, alu_alt_i, mul_i;
  logic             rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i;
  logic [2:0]       alu_op_i;
  logic [XLEN-1:0]  imm32_i, rf_data0_i, rf_data1_i, pc_plus1_i;
  logic [RF_AW-1:0] rf_waddr_i;
  logic             stall_o, valid_o, rf_we_o, mem_we_o, mem2rf_o, br_taken_o;
  logic [XLEN-1:0]  alu_result_o, mem_wdata_o, br_target_o;
  logic [RF_AW-1:0] rf_waddr_o;
  modport master (
    output valid_i, flush_i, has_imm_i, alu_alt_i, mul_i, rf_we_i, mem_we_i, mem2rf_i,
           branch_i, check_eq_i, alu_op_i, imm32_i, rf_data0_i, rf_data1_i, pc_plus1_i, rf_waddr_i,
    input  stall_o, valid_o, rf_we_o, mem_we_o, mem2rf_o, br_taken_o, alu_result_o,
           mem_wdata_o, br_target_o, rf_waddr_o
  );
  modport slave (
    input  valid_i, flush_i, has_imm_i, alu_alt_i, mul_i, rf_we_i, mem_we_i, mem2rf_i,
           branch_i, check_eq_i, alu_op_i, imm32_i, rf_data0_i, rf_data1_i, pc_plus1_i, rf_waddr_i,
    output stall_o, valid_o, rf_we_o, mem_we_o, mem2rf_o, br_taken_o, alu_result_o,
           mem_wdata_o, br_target_o, rf_waddr_o
  );
endinterface

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: 32-cycle shift-add unsigned multiplier with IDLE/BUSY control
module ex_mul_iter
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              last,
  output logic [2*XLEN-1:0] prod
);
  mul_state_e         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*XLEN-1:0]  m_q, m_d, acc_q, acc_d;
  logic [XLEN-1:0]    b_q, b_d;
  assign busy = state_q == ST_BUSY;
  assign last = busy && cnt_q == 5'(MUL_CYCLES - 1);
  assign prod = acc_q + (b_q[0] ? m_q : '0);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    b_d     = b_q;
    if (kill) state_d = ST_IDLE;
    else if (busy) begin
      state_d = last ? ST_IDLE : ST_BUSY;
      cnt_d   = cnt_q + 5'd1;
      acc_d   = prod;
      m_d     = m_q << 1;
      b_d     = b_q >> 1;
    end else if (start) begin
      state_d = ST_BUSY;
      cnt_d   = '0;
      m_d     = {{XLEN{1'b0}}, a};
      b_d     = b;
      acc_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage (ALU, branch, EX/MEM register); iterative multiplier under EX_MUL_EN
module ex_stage
  import ex_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_if.slave bus
);
  ex_mem_t         out_q, out_d;
  logic [XLEN-1:0] a, op_b, sra, alu_res, res;
  logic            fire, eq;
  assign a    = bus.rf_data0_i;
  assign op_b = bus.has_imm_i ? bus.imm32_i : bus.rf_data1_i;
  assign sra  = $unsigned($signed(a) >>> op_b[4:0]);
  assign eq   = bus.rf_data0_i == bus.rf_data1_i;
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(bus.alu_op_i))
      OP_ADD:  alu_res = bus.alu_alt_i ? a - op_b : a + op_b;
      OP_SLL:  alu_res = a << op_b[4:0];
      OP_SLT:  alu_res = {31'b0, $signed(a) < $signed(op_b)};
      OP_SLTU: alu_res = {31'b0, a < op_b};
      OP_XOR:  alu_res = a ^ op_b;
      OP_SRL:  alu_res = bus.alu_alt_i ? sra : a >> op_b[4:0];
      OP_OR:   alu_res = a | op_b;
      default: alu_res = a & op_b;
    endcase
  end
`ifdef EX_MUL_EN
  logic              busy, last, start;
  logic [2*XLEN-1:0] prod;
  assign start       = bus.valid_i & bus.mul_i & ~bus.flush_i & ~busy;
  assign bus.stall_o = start | (busy & ~last & ~bus.flush_i);
  assign fire        = bus.valid_i & ~bus.flush_i & (busy ? last : ~start);
  assign res         = busy ? (bus.alu_alt_i ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]) : alu_res;
  ex_mul_iter u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .kill  (bus.flush_i),
    .a     (a),
    .b     (op_b),
    .busy  (busy),
    .last  (last),
    .prod  (prod)
  );
`else
  assign bus.stall_o = 1'b0;
  assign fire        = bus.valid_i & ~bus.flush_i;
  assign res         = alu_res;
`endif
  always_comb begin
    out_d           = '0;
    out_d.valid     = fire;
    out_d.result    = res;
    out_d.wdata     = bus.rf_data1_i;
    out_d.waddr     = bus.rf_waddr_i;
    out_d.rf_we     = fire & bus.rf_we_i;
    out_d.mem_we    = fire & bus.mem_we_i;
    out_d.mem2rf    = fire & bus.mem2rf_i;
    out_d.br_taken  = fire & bus.branch_i & (bus.check_eq_i ? eq : ~eq);
    out_d.br_target = bus.pc_plus1_i + bus.imm32_i;
  end
  always_ff @(posedge clk) out_q <= rst ? '0 : out_d;
  assign bus.valid_o      = out_q.valid;
  assign bus.alu_result_o = out_q.result;
  assign bus.mem_wdata_o  = out_q.wdata;
  assign bus.rf_waddr_o   = out_q.waddr;
  assign bus.rf_we_o      = out_q.rf_we;
  assign bus.mem_we_o     = out_q.mem_we;
  assign bus.mem2rf_o     = out_q.mem2rf;
  assign bus.br_taken_o   = out_q.br_taken;
  assign bus.br_target_o  = out_q.br_target;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench with a reference model of the execute stage
module tb_ex_stage;
  import ex_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ex_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic alt, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] t;
    int unsigned sh;
    sh = int'(y[4:0]);
    t  = {{32{x[31]}}, x} >> sh;
    case (op)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return (x[31] != y[31]) ? {31'b0, x[31]} : {31'b0, x < y};
      3'd3: return {31'b0, x < y};
      3'd4: return x ^ y;
      3'd5: return alt ? t[31:0] : x >> sh;
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction
  logic        exp_valid, exp_rf_we, exp_mem_we, exp_mem2rf, exp_br;
  logic [31:0] exp_res, exp_wdata, exp_tgt;
  logic [4:0]  exp_waddr;
  bit          armed = 0;
  bit          m_busy = 0;
  int          cyc = 0;
  int          m_start = 0;
  logic [63:0] m_prod = '0;
  always @(posedge clk) begin
    logic        f;
    logic [31:0] opb, r;
    opb = bus.has_imm_i ? bus.imm32_i : bus.rf_data1_i;
    r   = alu_ref(bus.alu_op_i, bus.alu_alt_i, bus.rf_data0_i, opb);
    f   = bus.valid_i && !bus.flush_i;
`ifdef EX_MUL_EN
    if (m_busy) begin
      if (bus.flush_i) m_busy = 0;
      else if (cyc - m_start == MUL_CYCLES) begin
        m_busy = 0;
        r = bus.alu_alt_i ? m_prod[63:32] : m_prod[31:0];
      end else f = 0;
    end else if (f && bus.mul_i) begin
      m_busy  = 1;
      m_start = cyc;
      m_prod  = 64'(bus.rf_data0_i) * 64'(opb);
      f       = 0;
    end
`endif
    if (rst) m_busy = 0;
    exp_valid  <= !rst && f;
    exp_rf_we  <= !rst && f && bus.rf_we_i;
    exp_mem_we <= !rst && f && bus.mem_we_i;
    exp_mem2rf <= !rst && f && bus.mem2rf_i;
    exp_br     <= !rst && f && bus.branch_i && (bus.check_eq_i == (bus.rf_data0_i == bus.rf_data1_i));
    exp_res    <= rst ? 32'd0 : r;
    exp_wdata  <= rst ? 32'd0 : bus.rf_data1_i;
    exp_waddr  <= rst ? 5'd0 : bus.rf_waddr_i;
    exp_tgt    <= rst ? 32'd0 : bus.pc_plus1_i + bus.imm32_i;
    armed      <= 1;
    cyc        <= cyc + 1;
  end
  always @(negedge clk) if (armed) begin
    logic st;
`ifdef EX_MUL_EN
    st = m_busy ? (!bus.flush_i && cyc - m_start < MUL_CYCLES) : (bus.valid_i && bus.mul_i && !bus.flush_i);
`else
    st = 0;
`endif
    chk("stall", 64'(bus.stall_o), 64'(st));
    chk("valid", 64'(bus.valid_o), 64'(exp_valid));
    chk("rf_we", 64'(bus.rf_we_o), 64'(exp_rf_we));
    chk("mem_we", 64'(bus.mem_we_o), 64'(exp_mem_we));
    chk("mem2rf", 64'(bus.mem2rf_o), 64'(exp_mem2rf));
    chk("br_taken", 64'(bus.br_taken_o), 64'(exp_br));
    if (exp_valid) begin
      chk("result", 64'(bus.alu_result_o), 64'(exp_res));
      chk("wdata", 64'(bus.mem_wdata_o), 64'(exp_wdata));
      chk("waddr", 64'(bus.rf_waddr_o), 64'(exp_waddr));
      chk("target", 64'(bus.br_target_o), 64'(exp_tgt));
    end
  end
  task automatic idle();
    bus.valid_i = 0; bus.flush_i = 0; bus.has_imm_i = 0; bus.alu_op_i = 0; bus.alu_alt_i = 0;
    bus.mul_i = 0; bus.rf_we_i = 0; bus.mem_we_i = 0; bus.mem2rf_i = 0; bus.branch_i = 0;
    bus.check_eq_i = 0; bus.imm32_i = 0; bus.rf_data0_i = 0; bus.rf_data1_i = 0;
    bus.pc_plus1_i = 0; bus.rf_waddr_i = 0;
  endtask
  task automatic alu(input logic [2:0] op, input logic alt, input logic [31:0] x, input logic [31:0] y, input logic use_imm);
    idle();
    bus.valid_i = 1; bus.alu_op_i = op; bus.alu_alt_i = alt; bus.rf_data0_i = x;
    if (use_imm) begin
      bus.has_imm_i = 1;
      bus.imm32_i = y;
    end else bus.rf_data1_i = y;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
`ifdef EX_MUL_EN
  task automatic run_mul(input logic alt, input logic [31:0] want);
    int n, pulses;
    n = 0;
    pulses = 0;
    alu(3'd0, alt, 32'hFFFFFFFF, 32'd2, 1'b0);
    bus.mul_i = 1; bus.rf_we_i = 1; bus.rf_waddr_i = 5'd7;
    #1;
    while (bus.stall_o && n < 40) begin
      n++;
      tick();
      #1;
      pulses += int'(bus.valid_o);
    end
    chk("mul_stall_len", 64'(n), 64'd32);
    tick();
    pulses += int'(bus.valid_o);
    chk("mul_result", 64'(bus.alu_result_o), 64'(want));
    chk("mul_rf_we", 64'(bus.rf_we_o), 64'd1);
    idle();
    tick();
    pulses += int'(bus.valid_o);
    chk("mul_pulses", 64'(pulses), 64'd1);
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    idle();
    repeat (2) tick();
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_result", 64'(bus.alu_result_o), 64'd0);
    chk("rst_target", 64'(bus.br_target_o), 64'd0);
    rst = 0;
    alu(3'd0, 1'b0, 32'd5, 32'hFFFFFFFF, 1'b1);
    bus.rf_we_i = 1; bus.rf_waddr_i = 5'd3;
    tick();
    chk("add_result", 64'(bus.alu_result_o), 64'd4);
    chk("add_valid", 64'(bus.valid_o), 64'd1);
    chk("add_rf_we", 64'(bus.rf_we_o), 64'd1);
    alu(3'd0, 1'b1, 32'd3, 32'd5, 1'b0);
    tick();
    chk("sub_result", 64'(bus.alu_result_o), 64'hFFFFFFFE);
    alu(3'd5, 1'b1, 32'h80000000, 32'd4, 1'b1);
    tick();
    chk("sra_result", 64'(bus.alu_result_o), 64'hF8000000);
    alu(3'd5, 1'b0, 32'h80000000, 32'd4, 1'b1);
    tick();
    chk("srl_result", 64'(bus.alu_result_o), 64'h08000000);
    alu(3'd2, 1'b0, 32'h80000000, 32'd1, 1'b1);
    tick();
    chk("slt_result", 64'(bus.alu_result_o), 64'd1);
    alu(3'd3, 1'b0, 32'h80000000, 32'd1, 1'b1);
    tick();
    chk("sltu_result", 64'(bus.alu_result_o), 64'd0);
    alu(3'd1, 1'b0, 32'd1, 32'd31, 1'b0);
    tick();
    chk("sll_result", 64'(bus.alu_result_o), 64'h80000000);
    alu(3'd0, 1'b0, 32'd7, 32'd7, 1'b0);
    bus.branch_i = 1; bus.pc_plus1_i = 32'h100; bus.imm32_i = 32'h20;
    tick();
    chk("bne_equal", 64'(bus.br_taken_o), 64'd0);
    bus.rf_data1_i = 32'd8;
    tick();
    chk("bne_taken", 64'(bus.br_taken_o), 64'd1);
    chk("br_target", 64'(bus.br_target_o), 64'h120);
    bus.check_eq_i = 1; bus.rf_data1_i = 32'd7;
    tick();
    chk("beq_taken", 64'(bus.br_taken_o), 64'd1);
    alu(3'd0, 1'b0, 32'd1, 32'd1, 1'b0);
    bus.rf_we_i = 1; bus.mem_we_i = 1; bus.flush_i = 1;
    tick();
    chk("flush_valid", 64'(bus.valid_o), 64'd0);
    chk("flush_mem_we", 64'(bus.mem_we_o), 64'd0);
    for (int i = 0; i < 16; i++) begin
      alu(3'(i), i[3], 32'h9E3779B9 * 32'(i + 1), 32'h7F4A7C15 ^ (32'hFFFF << i), i[0]);
      bus.rf_we_i = i[1]; bus.mem_we_i = i[2]; bus.mem2rf_i = ~i[1];
      bus.rf_waddr_i = 5'(i * 3); bus.pc_plus1_i = 32'(i * 4); bus.imm32_i = bus.imm32_i + 32'(i);
      bus.branch_i = i[2]; bus.check_eq_i = i[0];
      tick();
    end
    idle();
    bus.mul_i = 1;
    #1;
    chk("mul_no_valid_stall", 64'(bus.stall_o), 64'd0);
    tick();
`ifdef EX_MUL_EN
    run_mul(1'b0, 32'hFFFFFFFE);
    run_mul(1'b1, 32'h00000001);
    alu(3'd0, 1'b0, 32'd9, 32'd9, 1'b0);
    bus.mul_i = 1;
    repeat (10) tick();
    bus.flush_i = 1;
    #1;
    chk("mul_flush_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("mul_flush_valid", 64'(bus.valid_o), 64'd0);
    alu(3'd0, 1'b0, 32'd20, 32'd22, 1'b0);
    #1;
    chk("post_flush_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("post_flush_add", 64'(bus.alu_result_o), 64'd42);
    chk("post_flush_valid", 64'(bus.valid_o), 64'd1);
    alu(3'd0, 1'b0, 32'd3, 32'd4, 1'b0);
    bus.mul_i = 1; bus.rf_we_i = 1;
    repeat (5) tick();
    rst = 1;
    idle();
    tick();
    rst = 0;
    chk("mul_rst_valid", 64'(bus.valid_o), 64'd0);
    chk("mul_rst_result", 64'(bus.alu_result_o), 64'd0);
    chk("mul_rst_stall", 64'(bus.stall_o), 64'd0);
`else
    alu(3'd0, 1'b0, 32'd5, 32'd6, 1'b0);
    bus.mul_i = 1;
    #1;
    chk("nomul_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("nomul_add", 64'(bus.alu_result_o), 64'd11);
    chk("nomul_valid", 64'(bus.valid_o), 64'd1);
`endif
    idle();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline.
- Consumes the decode/execute pipeline register outputs and computes the ALU result, branch decision and branch target.
- Registers everything into the execute/memory boundary, so outputs appear one cycle after the inputs.
- Hosts an iterative 32-cycle multiplier; while it runs, stall_o freezes PC, fetch/decode and decode/execute registers.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  decode/execute holds a live instruction.
- flush_i  in  1  kill the instruction in EX (mispredict or redirect).
- has_imm_i  in  1  operand B = imm32_i, else rf_data1_i.
- alu_op_i  in  3  ALU function.
- alu_alt_i  in  1  SUB/SRA select; for multiply, selects high word.
- mul_i  in  1  instruction is a multiply.
- rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i  in  1 each  control bits from decode.
- imm32_i, rf_data0_i, rf_data1_i, pc_plus1_i  in  32 each  operands and next PC.
- rf_waddr_i  in  RF_AW  destination register.
- stall_o  out  1  combinational; hold all upstream registers.
- valid_o  out  1  execute/memory stage holds a live instruction.
- alu_result_o  out  32  ALU or multiply result.
- mem_wdata_o  out  32  registered rf_data1_i.
- rf_waddr_o  out  RF_AW  registered destination register.
- rf_we_o, mem_we_o, mem2rf_o  out  1 each  registered controls, gated by valid_o.
- br_taken_o  out  1  registered branch decision.
- br_target_o  out  32  pc_plus1_i + imm32_i; decode pre-adjusts the offset.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; counter 0. Reset mid-multiply aborts it with no output.
- Operands: A = rf_data0_i; B = has_imm_i ? imm32_i : rf_data1_i.
- ALU ops:
  - 0: ADD, or SUB when alu_alt_i.
  - 1: SLL by B[4:0].
  - 2: SLT (signed).
  - 3: SLTU.
  - 4: XOR.
  - 5: SRL, or SRA when alu_alt_i.
  - 6: OR.
  - 7: AND.
- Arithmetic wraps modulo 2^32.
- Branch: br_taken = branch_i & (check_eq_i ? rf_data0_i == rf_data1_i : rf_data0_i != rf_data1_i). Always compares registers, never the immediate.
- Non-multiply ops: one-cycle latency.
  - valid_o(t+1) = valid_i(t) & ~flush_i(t).
  - When valid_o is 0: rf_we_o, mem_we_o, mem2rf_o and br_taken_o are forced to 0 (bubble).
- FSM states are IDLE and BUSY.
- IDLE:
  - Start condition: valid_i & mul_i & ~flush_i.
  - On start, load multiplicand A, multiplier B and a 64-bit accumulator of 0. Set cnt = 0 and go to BUSY.
  - Output register takes a bubble in the start cycle.
- BUSY:
  - One shift-add iteration per cycle; unsigned product.
  - cnt increments each cycle. On cnt == 31, the final iteration runs, the result is registered and the FSM returns to IDLE.
  - Result: alu_alt_i = 0 gives product[31:0] (MUL); alu_alt_i = 1 gives product[63:32] (MULHU).
- Stall: stall_o = (IDLE & start) | (BUSY & cnt != 31).
  - With start at cycle T, stall_o is high for T..T+31.
  - Upstream re-presents the same multiply at T+32; it is not restarted because the FSM is in BUSY.
  - The result is visible with valid_o = 1 at T+33.
  - valid_o = 0 during T+1..T+32.
- Flush:
  - flush_i in IDLE gives a bubble next cycle.
  - flush_i in BUSY aborts to IDLE next cycle, drops stall_o combinationally and produces a bubble.
  - flush_i together with start: flush wins and nothing starts.
- valid_i = 0 with mul_i = 1: no start.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: the multiplier and FSM are present, as specified above.
- Undefined:
  - No multiplier state is built, stall_o is tied to 0, and mul_i is ignored.
  - The instruction executes as its alu_op_i and alu_alt_i encode, with one-cycle latency.

Decomposition:
- Package ex_pkg: the alu_op enum (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND), the mul FSM state enum, and the constant MUL_CYCLES = 32.
- Sub-module ex_mul_iter: the shift-add core.
  - Inputs: start, kill, a, b.
  - Outputs: busy, last, prod[63:0].
- ALU, branch compare and the output register stay in ex_stage.

Test Plan:
- ADD x, imm: rf_data0 = 5, imm32 = 0xFFFFFFFF, has_imm = 1, op 0 -> next cycle alu_result_o = 4, valid_o = 1, rf_we_o passed through.
- Shifts and SLT: rf_data0 = 0x80000000, B = 4.
  - SRA -> 0xF8000000.
  - SRL -> 0x08000000.
  - SLT against 1 -> 1; SLTU against 1 -> 0.
- Branch: branch = 1, check_eq = 0, rf_data0 = rf_data1 = 7 -> br_taken_o = 0. With rf_data1 = 8 -> br_taken_o = 1 and br_target_o = pc_plus1 + imm.
- MUL, EX_MUL_EN defined: A = 0xFFFFFFFF, B = 2.
  - stall_o high for exactly 32 cycles starting T.
  - At T+33: MUL -> 0xFFFFFFFE, MULHU -> 0x00000001.
  - Only one valid_o pulse is produced.
- Flush at T+10 of a multiply -> stall_o low that cycle, no valid_o, FSM in IDLE. A following ADD completes with one-cycle latency.
- Assert rst at T+5 of a multiply -> all outputs 0 next cycle, stall_o 0. Build without EX_MUL_EN -> mul_i = 1 with op 0 yields the ADD result and stall_o is never asserted.
